rv_decode_stage: RTL and testbench

//  Registered RV32I decode stage with a valid/ready handshake. Accepts {pc, instr} from fetch,

---
 rtl/rv_decode_stage_pkg.sv | 50 +++++
 rtl/rv_decode_stage_fields.sv | 65 ++++++
 rtl/rv_decode_stage_reghelper.sv | 13 +
 rtl/rv_decode_stage.sv | 136 +++++++++++++
 tb/tb_rv_decode_stage.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_decode_stage_pkg.sv
// Shared RV32I decode definitions: format codes, opcode constants, decoded-entry
// layout and the register-name string helper.
package rv_decode_stage_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int unsigned NAME_W = 256;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        fmt_e        fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } dec_entry_t;

    // ASCII "x<n>" right-justified in a 256-bit vector, zero-filled on the left.
    function automatic logic [NAME_W-1:0] reg_name(input logic [4:0] id);
        logic [7:0] tens;
        logic [7:0] ones;
        tens = 8'h30 + 8'(id / 5'd10);
        ones = 8'h30 + 8'(id % 5'd10);
        if (id < 5'd10)
            return {240'd0, 8'h78, ones};
        else
            return {232'd0, 8'h78, tens, ones};
    endfunction

endpackage

// File: rtl/rv_decode_stage_fields.sv
// Combinational RV32I field extraction: format, register ids, immediate, illegal flag.
module rv_decode_fields
    import rv_decode_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    output fmt_e        fmt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [31:0] imm_o,
    output logic        illegal_o
);

    always_comb begin
        fmt_o     = FMT_ILL;
        rd_o      = '0;
        rs1_o     = '0;
        rs2_o     = '0;
        imm_o     = '0;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                rd_o  = instr_i[11:7];
                imm_o = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                rd_o  = instr_i[11:7];
                imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                fmt_o = FMT_I;
                rd_o  = instr_i[11:7];
                rs1_o = instr_i[19:15];
                imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                rs1_o = instr_i[19:15];
                rs2_o = instr_i[24:20];
                imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                rs1_o = instr_i[19:15];
                rs2_o = instr_i[24:20];
                imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_OP: begin
                fmt_o = FMT_R;
                rd_o  = instr_i[11:7];
                rs1_o = instr_i[19:15];
                rs2_o = instr_i[24:20];
            end
            default: begin
                fmt_o = FMT_ILL;
            end
        endcase
        illegal_o = (fmt_o == FMT_ILL);
    end

endmodule

// File: rtl/rv_decode_stage_reghelper.sv
// REGHELPER: maps a register id to its printable name.
module REGHELPER
    import rv_decode_stage_pkg::*;
(
    input  logic [4:0]        id_i,
    output logic [NAME_W-1:0] name_o
);

    always_comb begin
        name_o = reg_name(id_i);
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: decode on input, two-entry (head + skid) buffer,
// register names from head ids, and a retire counter.
module rv_decode_stage
    import rv_decode_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [2:0]        out_fmt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [31:0]       out_imm,
    output logic [NAME_W-1:0] out_rd_name,
    output logic [NAME_W-1:0] out_rs1_name,
    output logic [NAME_W-1:0] out_rs2_name,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  instr_count
);

    dec_entry_t       in_dec;
    fmt_e             dec_fmt;
    logic [4:0]       dec_rd;
    logic [4:0]       dec_rs1;
    logic [4:0]       dec_rs2;
    logic [31:0]      dec_imm;
    logic             dec_illegal;

    dec_entry_t       head_q, head_d;
    dec_entry_t       skid_q, skid_d;
    logic             head_vld_q, head_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             pop;

    rv_decode_fields u_fields (
        .instr_i   (in_instr),
        .fmt_o     (dec_fmt),
        .rd_o      (dec_rd),
        .rs1_o     (dec_rs1),
        .rs2_o     (dec_rs2),
        .imm_o     (dec_imm),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        in_dec         = '0;
        in_dec.pc      = in_pc;
        in_dec.instr   = in_instr;
        in_dec.fmt     = dec_fmt;
        in_dec.rd      = dec_rd;
        in_dec.rs1     = dec_rs1;
        in_dec.rs2     = dec_rs2;
        in_dec.imm     = dec_imm;
        in_dec.illegal = dec_illegal;
    end

    // in_ready depends only on the skid flop, so a push never coincides with a full buffer.
    always_comb begin
        push       = in_valid && !skid_vld_q;
        pop        = head_vld_q && out_ready;
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        cnt_d      = pop ? cnt_q + CNT_W'(1) : cnt_q;

        if (flush) begin
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (pop) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                head_vld_d = push;
                if (push)
                    head_d = in_dec;
            end
        end else if (push) begin
            if (head_vld_q) begin
                skid_d     = in_dec;
                skid_vld_d = 1'b1;
            end else begin
                head_d     = in_dec;
                head_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        in_ready    = !skid_vld_q;
        out_valid   = head_vld_q;
        out_pc      = head_q.pc;
        out_instr   = head_q.instr;
        out_fmt     = head_q.fmt;
        out_rd      = head_q.rd;
        out_rs1     = head_q.rs1;
        out_rs2     = head_q.rs2;
        out_imm     = head_q.imm;
        out_illegal = head_q.illegal;
        instr_count = cnt_q;
    end

    REGHELPER u_rd_name  (.id_i(head_q.rd),  .name_o(out_rd_name));
    REGHELPER u_rs1_name (.id_i(head_q.rs1), .name_o(out_rs1_name));
    REGHELPER u_rs2_name (.id_i(head_q.rs2), .name_o(out_rs2_name));

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: expected decodes queued on accept, compared on retire.
module tb_rv_decode_stage;

    localparam int CW = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic [2:0]    out_fmt;
    logic [4:0]    out_rd;
    logic [4:0]    out_rs1;
    logic [4:0]    out_rs2;
    logic [31:0]   out_imm;
    logic [255:0]  out_rd_name;
    logic [255:0]  out_rs1_name;
    logic [255:0]  out_rs2_name;
    logic          out_illegal;
    logic [CW-1:0] instr_count;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   exp_count = 0;

    rv_decode_stage #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_fmt(out_fmt), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_rd_name(out_rd_name), .out_rs1_name(out_rs1_name),
        .out_rs2_name(out_rs2_name), .out_illegal(out_illegal), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] nm(input logic [4:0] id);
        string s;
        logic [255:0] v;
        s = $sformatf("x%0d", id);
        v = '0;
        for (int i = 0; i < s.len(); i++) v = {v[247:0], s[i]};
        return v;
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        e.pc = pc; e.instr = ins; e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.imm = 0; e.ill = 0;
        case (ins[6:0])
            7'h37, 7'h17: begin
                e.fmt = 3'd4; e.rd = ins[11:7]; e.imm = {ins[31:12], 12'h000};
            end
            7'h6F: begin
                e.fmt = 3'd5; e.rd = ins[11:7];
                e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'h67, 7'h03, 7'h13: begin
                e.fmt = 3'd1; e.rd = ins[11:7]; e.rs1 = ins[19:15];
                e.imm = {{20{ins[31]}}, ins[31:20]};
            end
            7'h63: begin
                e.fmt = 3'd3; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
                e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'h23: begin
                e.fmt = 3'd2; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
                e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'h33: begin
                e.fmt = 3'd0; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
            end
            default: begin
                e.fmt = 3'd7; e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[6:0] = 7'h37;
            1: r[6:0] = 7'h17;
            2: r[6:0] = 7'h6F;
            3: r[6:0] = 7'h67;
            4: r[6:0] = 7'h03;
            5: r[6:0] = 7'h13;
            6: r[6:0] = 7'h63;
            7: r[6:0] = 7'h23;
            8: r[6:0] = 7'h33;
            default: r[6:0] = 7'h7F;
        endcase
        return r;
    endfunction

    // One clock: retire-compare and accept-push observed at the falling edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL retire_unexpected got pc=%h instr=%h required=no_output", out_pc, out_instr);
            end else begin
                e = sb.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr || out_fmt !== e.fmt ||
                    out_rd !== e.rd || out_rs1 !== e.rs1 || out_rs2 !== e.rs2 ||
                    out_imm !== e.imm || out_illegal !== e.ill ||
                    out_rd_name !== nm(e.rd) || out_rs1_name !== nm(e.rs1) ||
                    out_rs2_name !== nm(e.rs2)) begin
                    failures++;
                    $display("FAIL retire_fields got pc=%h instr=%h fmt=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b required pc=%h instr=%h fmt=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b",
                             out_pc, out_instr, out_fmt, out_rd, out_rs1, out_rs2, out_imm, out_illegal,
                             e.pc, e.instr, e.fmt, e.rd, e.rs1, e.rs2, e.imm, e.ill);
                end
            end
            checks++;
            if (instr_count !== CW'(exp_count)) begin
                failures++;
                $display("FAIL retire_count got=%0d required=%0d", instr_count, CW'(exp_count));
            end
            exp_count++;
        end
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(model(in_pc, in_instr));
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] ins);
        bit got;
        int n;
        got = 0; n = 0;
        in_valid = 1'b1; in_pc = pc; in_instr = ins;
        while (!got && n < 50) begin
            got = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL offer_timeout got in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1; in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid) && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain got pending=%0d out_valid=%b required pending=0 out_valid=0", sb.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_count !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got out_valid=%b in_ready=%b count=%0d required 0 1 0", out_valid, in_ready, instr_count);
        end
        checks++;
        if (out_pc !== '0 || out_instr !== '0 || out_imm !== '0 || out_rd !== '0 || out_fmt !== '0) begin
            failures++;
            $display("FAIL reset_data got pc=%h instr=%h imm=%h rd=%0d fmt=%0d required all 0", out_pc, out_instr, out_imm, out_rd, out_fmt);
        end
        checks++;
        if (out_rd_name !== nm(5'd0) || out_rs1_name !== nm(5'd0) || out_rs2_name !== nm(5'd0)) begin
            failures++;
            $display("FAIL reset_names got rd=%h required=%h", out_rd_name, nm(5'd0));
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) offer(32'h1000 + 32'(i * 4), rnd_instr());
        drain();
        checks++;
        if (instr_count !== 4'd1) begin
            failures++;
            $display("FAIL count_wrap got=%0d required=1", instr_count);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] ins [4] = '{32'h002081B3, 32'hFFF00293, 32'h0020A423, 32'h00000000};
        logic [2:0]  fmt [4] = '{3'd0, 3'd1, 3'd2, 3'd7};
        logic [4:0]  rd  [4] = '{5'd3, 5'd5, 5'd0, 5'd0};
        logic [4:0]  rs1 [4] = '{5'd1, 5'd0, 5'd1, 5'd0};
        logic [4:0]  rs2 [4] = '{5'd2, 5'd0, 5'd2, 5'd0};
        logic [31:0] imm [4] = '{32'h0, 32'hFFFFFFFF, 32'h8, 32'h0};
        logic        ill [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b0;
            offer(32'h2000 + 32'(i * 4), ins[i]);
            checks++;
            if (out_valid !== 1'b1 || out_fmt !== fmt[i] || out_rd !== rd[i] || out_rs1 !== rs1[i] ||
                out_rs2 !== rs2[i] || out_imm !== imm[i] || out_illegal !== ill[i]) begin
                failures++;
                $display("FAIL vector_%0d got v=%b fmt=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b required v=1 fmt=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%b",
                         i, out_valid, out_fmt, out_rd, out_rs1, out_rs2, out_imm, out_illegal,
                         fmt[i], rd[i], rs1[i], rs2[i], imm[i], ill[i]);
            end
            drain();
        end
        checks++;
        if (instr_count !== CW'(exp_count)) begin
            failures++;
            $display("FAIL vector_count got=%0d required=%0d", instr_count, CW'(exp_count));
        end
    endtask

    task automatic test_backpressure();
        int base;
        int n;
        bit got;
        base = exp_count;
        out_ready = 1'b0;
        offer(32'h3000, 32'h00500093);
        offer(32'h3004, 32'h00A10113);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_full got in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
        end
        in_valid = 1'b1; in_pc = 32'h3008; in_instr = 32'h002081B3;
        step();
        step();
        checks++;
        if (in_ready !== 1'b0 || out_pc !== 32'h3000) begin
            failures++;
            $display("FAIL bp_hold got in_ready=%b head_pc=%h required 0 00003000", in_ready, out_pc);
        end
        out_ready = 1'b1;
        got = 0; n = 0;
        while (!got && n < 10) begin
            got = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL bp_third_accept got=0 required=1");
        end
        drain();
        checks++;
        if (instr_count !== CW'(base + 3)) begin
            failures++;
            $display("FAIL bp_count got=%0d required=%0d", instr_count, CW'(base + 3));
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'h4000, 32'h00100093);
        offer(32'h4004, 32'h00200113);
        in_valid = 1'b1; in_pc = 32'h4008; in_instr = 32'h00300193;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_state got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_dropped got out_valid=%b required=0", out_valid);
        end
        offer(32'h4010, 32'h00400213);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || instr_count !== CW'(exp_count)) begin
            failures++;
            $display("FAIL flush_pop got out_valid=%b count=%0d required 0 %0d", out_valid, instr_count, CW'(exp_count));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_pc     = $urandom;
            in_instr  = rnd_instr();
            step();
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        offer(32'h5000, 32'h00100093);
        offer(32'h5004, 32'h0020A423);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || instr_count !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got out_valid=%b count=%0d in_ready=%b required 0 0 1", out_valid, instr_count, in_ready);
        end
        sb.delete();
        exp_count = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after got out_valid=%b required=0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_vectors();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
